// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences two-word add/sub/compare and multi-cycle shifts over an external single-word ALU
module alu_seq_ctrl #(
  parameter int         WIDTH  = 8,
  parameter logic [3:0] OP_ADD = 4'h0,
  parameter logic [3:0] OP_ADC = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_SBC = 4'h3,
  parameter logic [3:0] OP_LSL = 4'h8,
  parameter logic [3:0] OP_LSR = 4'h9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           cmd,
  input  logic [2*WIDTH-1:0]   op_a,
  input  logic [2*WIDTH-1:0]   op_b,
  input  logic [3:0]           shamt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic [3:0]           alu_oper,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_c_in,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_c_out,
  input  logic                 alu_z_out
);
  typedef enum logic [1:0] {IDLE, LO, HI, SHIFT} state_t;
  state_t             state_q;
  logic [2:0]         cmd_q;
  logic [2*WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic [3:0]         shamt_q, cnt_q;
  logic [WIDTH-1:0]   lo_q;
  logic               c_q, z_lo_q, first_q, done_q, err_q, flag_c_q, flag_z_q;
  logic               sub, lsl, valid, to_shift;
  // ALU drive is a pure decode of the registered state so the ALU answers within the same cycle
  always_comb begin
    sub      = cmd_q != 3'b000;
    lsl      = cmd_q == 3'b011;
    valid    = cmd <= 3'b100;
    to_shift = cmd == 3'b011 || cmd == 3'b100;
    alu_oper = state_q == LO ? (sub ? OP_SUB : OP_ADD) :
               state_q == HI ? (sub ? OP_SBC : OP_ADC) :
               state_q == SHIFT ? (lsl ? OP_LSL : OP_LSR) : OP_ADD;
    alu_a    = state_q == LO ? op_a_q[WIDTH-1:0] :
               state_q == HI ? op_a_q[2*WIDTH-1:WIDTH] :
               state_q == SHIFT ? (first_q ? op_a_q[WIDTH-1:0] : lo_q) : '0;
    alu_b    = state_q == LO ? op_b_q[WIDTH-1:0] :
               state_q == HI ? op_b_q[2*WIDTH-1:WIDTH] : '0;
    alu_c_in = state_q == HI && c_q;
    busy     = state_q != IDLE;
    done     = done_q;
    err      = err_q;
    result   = result_q;
    flag_c   = flag_c_q;
    flag_z   = flag_z_q;
  end
  // Command FSM; lo_q doubles as the low-word result and the running shift value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      shamt_q  <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      c_q      <= 1'b0;
      z_lo_q   <= 1'b0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (!valid) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            cmd_q   <= cmd;
            op_a_q  <= op_a;
            op_b_q  <= op_b;
            shamt_q <= shamt;
            cnt_q   <= shamt == 4'd0 ? 4'd0 : shamt - 4'd1;
            first_q <= 1'b1;
            state_q <= to_shift ? SHIFT : LO;
          end
        end
        LO: begin
          lo_q    <= alu_out;
          c_q     <= alu_c_out;
          z_lo_q  <= alu_z_out;
          state_q <= HI;
        end
        HI: begin
          flag_c_q <= alu_c_out;
          flag_z_q <= z_lo_q & alu_z_out;
          if (cmd_q != 3'b010) result_q <= {alu_out, lo_q};
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        SHIFT: begin
          first_q <= 1'b0;
          lo_q    <= alu_out;
          cnt_q   <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
            if (shamt_q == 4'd0) begin
              result_q <= {{WIDTH{1'b0}}, op_a_q[WIDTH-1:0]};
              flag_z_q <= op_a_q[WIDTH-1:0] == '0;
            end else begin
              result_q <= {{WIDTH{1'b0}}, alu_out};
              flag_c_q <= alu_c_out;
              flag_z_q <= alu_z_out;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench with a behavioural ALU and a queue of expected command results
module tb_alu_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  cmd = '0;
  logic [15:0] op_a = '0, op_b = '0, result;
  logic [3:0]  shamt = '0, alu_oper;
  logic        busy, done, err, flag_c, flag_z, alu_c_in, alu_c_out, alu_z_out;
  logic [7:0]  alu_a, alu_b, alu_out;
  int          chk = 0, errs = 0;
  typedef struct {logic [15:0] res; logic c; logic z; logic err; int lat;} exp_t;
  exp_t        q[$];
  logic [15:0] exp_res = '0;
  logic        exp_c = 1'b0, exp_z = 1'b0;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .shamt(shamt), .busy(busy), .done(done), .err(err), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .alu_oper(alu_oper), .alu_a(alu_a),
    .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_out(alu_out), .alu_c_out(alu_c_out),
    .alu_z_out(alu_z_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-word ALU; shifts move one bit per cycle
  always_comb begin
    {alu_c_out, alu_out} = 9'h0;
    case (alu_oper)
      4'h0: {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_c_in);
      4'h2: {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      4'h3: {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_c_in);
      4'h8: {alu_c_out, alu_out} = {alu_a, 1'b0};
      4'h9: {alu_c_out, alu_out} = {alu_a[0], 1'b0, alu_a[7:1]};
      default: {alu_c_out, alu_out} = 9'h0;
    endcase
  end
  assign alu_z_out = alu_out == 8'h00;

  function automatic exp_t model(input logic [2:0] c, input logic [15:0] a, b, input logic [3:0] s);
    exp_t e;
    logic [16:0] t;
    logic [7:0] l;
    int si;
    e.res = exp_res; e.c = exp_c; e.z = exp_z; e.err = 1'b0; e.lat = 2;
    l = a[7:0]; si = int'(s);
    if (c == 3'd0) begin
      t = {1'b0, a} + {1'b0, b};
      e.res = t[15:0]; e.c = t[16]; e.z = t[15:0] == 16'h0;
    end else if (c == 3'd1) begin
      e.res = a - b; e.c = a >= b; e.z = a == b;
    end else if (c == 3'd2) begin
      e.c = a >= b; e.z = a == b;
    end else if (c == 3'd3 || c == 3'd4) begin
      e.lat = si == 0 ? 1 : si;
      if (si == 0) begin
        e.res = {8'h0, l};
      end else if (c == 3'd3) begin
        e.res = {8'h0, 8'(l << si)};
        e.c = 1'b0;
        if (si <= 8) e.c = l[8-si];
      end else begin
        e.res = {8'h0, l >> si};
        e.c = 1'b0;
        if (si <= 8) e.c = l[si-1];
      end
      e.z = e.res == 16'h0;
    end else begin
      e.err = 1'b1; e.lat = 0;
    end
    exp_res = e.res; exp_c = e.c; exp_z = e.z;
    return e;
  endfunction

  // Issues one command starting at the current negedge and returns at the negedge where done is seen
  task automatic run(input logic [2:0] c, input logic [15:0] a, b, input logic [3:0] s);
    exp_t e0, e;
    int n;
    e0 = model(c, a, b, s);
    q.push_back(e0);
    start = 1'b1; cmd = c; op_a = a; op_b = b; shamt = s;
    @(negedge clk);
    start = 1'b0; n = 0;
    chk++;
    if (busy !== ~e0.err) begin errs++; $display("FAIL busy_after_start cmd=%0d got %b want %b", c, busy, ~e0.err); end
    if (!e0.err) begin
      chk++;
      if (done !== 1'b0) begin errs++; $display("FAIL done_width cmd=%0d got %b want 0", c, done); end
    end
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    e = q.pop_front();
    chk++;
    if (done !== 1'b1) begin errs++; $display("FAIL timeout cmd=%0d got no done want done", c); end
    chk++;
    if (n != e.lat) begin errs++; $display("FAIL latency cmd=%0d s=%0d got %0d want %0d", c, s, n, e.lat); end
    chk++;
    if (err !== e.err) begin errs++; $display("FAIL err cmd=%0d got %b want %b", c, err, e.err); end
    chk++;
    if (result !== e.res) begin errs++; $display("FAIL result cmd=%0d a=%h b=%h s=%0d got %h want %h", c, a, b, s, result, e.res); end
    chk++;
    if (flag_c !== e.c) begin errs++; $display("FAIL flag_c cmd=%0d a=%h b=%h s=%0d got %b want %b", c, a, b, s, flag_c, e.c); end
    chk++;
    if (flag_z !== e.z) begin errs++; $display("FAIL flag_z cmd=%0d a=%h b=%h s=%0d got %b want %b", c, a, b, s, flag_z, e.z); end
    chk++;
    if (busy !== 1'b0) begin errs++; $display("FAIL busy_at_done cmd=%0d got %b want 0", c, busy); end
  endtask

  task automatic test_reset;
    #2;
    chk++;
    if ({busy, done, err, flag_c, flag_z} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {busy, done, err, flag_c, flag_z}); end
    chk++;
    if (result !== 16'h0) begin errs++; $display("FAIL reset_result got %h want 0000", result); end
    chk++;
    if ({alu_oper, alu_a, alu_b, alu_c_in} !== 21'h0) begin errs++; $display("FAIL reset_alu_drive got %h want 0", {alu_oper, alu_a, alu_b, alu_c_in}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    run(3'd0, 16'hFFFF, 16'h0001, 4'd0);
    run(3'd0, 16'h12F0, 16'h0F20, 4'd0);
    run(3'd0, 16'h8000, 16'h8001, 4'd0);
  endtask

  task automatic test_sub;
    exp_t e;
    q.push_back(model(3'd1, 16'h0100, 16'h0001, 4'd0));
    start = 1'b1; cmd = 3'd1; op_a = 16'h0100; op_b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    chk++;
    if ({alu_oper, alu_out, alu_c_out} !== {4'h2, 8'hFF, 1'b0}) begin errs++; $display("FAIL sub_lo got oper=%h out=%h c=%b want oper=2 out=ff c=0", alu_oper, alu_out, alu_c_out); end
    @(negedge clk);
    chk++;
    if ({alu_oper, alu_c_in, done} !== {4'h3, 1'b0, 1'b0}) begin errs++; $display("FAIL sub_hi got oper=%h cin=%b done=%b want oper=3 cin=0 done=0", alu_oper, alu_c_in, done); end
    @(negedge clk);
    e = q.pop_front();
    chk++;
    if ({done, result, flag_c, flag_z} !== {1'b1, e.res, e.c, e.z}) begin errs++; $display("FAIL sub_result got done=%b res=%h c=%b z=%b want done=1 res=%h c=%b z=%b", done, result, flag_c, flag_z, e.res, e.c, e.z); end
    run(3'd1, 16'h1234, 16'h5678, 4'd0);
  endtask

  task automatic test_cmp;
    run(3'd0, 16'hABCD, 16'h0000, 4'd0);
    run(3'd2, 16'h1234, 16'h1234, 4'd0);
    run(3'd2, 16'h0100, 16'h0200, 4'd0);
  endtask

  task automatic test_shift;
    run(3'd4, 16'h0081, 16'h0000, 4'd3);
    run(3'd3, 16'h0081, 16'h0000, 4'd1);
    run(3'd4, 16'h00A5, 16'h0000, 4'd0);
    run(3'd3, 16'h0000, 16'h0000, 4'd0);
    run(3'd3, 16'hFF81, 16'h0000, 4'd8);
    run(3'd4, 16'h00FF, 16'h0000, 4'd15);
    run(3'd3, 16'h00C3, 16'h0000, 4'd7);
  endtask

  task automatic test_invalid;
    run(3'd0, 16'h4242, 16'h0101, 4'd0);
    run(3'd7, 16'hFFFF, 16'hFFFF, 4'd2);
    run(3'd5, 16'h0000, 16'h0001, 4'd0);
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    q.push_back(model(3'd0, 16'h1111, 16'h2222, 4'd0));
    start = 1'b1; cmd = 3'd0; op_a = 16'h1111; op_b = 16'h2222;
    @(negedge clk);
    cmd = 3'd1; op_a = 16'hFFFF; op_b = 16'h0001; shamt = 4'd5;
    @(negedge clk);
    chk++;
    if ({busy, alu_a, alu_b} !== {1'b1, 8'h11, 8'h22}) begin errs++; $display("FAIL busy_hold got busy=%b a=%h b=%h want busy=1 a=11 b=22", busy, alu_a, alu_b); end
    @(negedge clk);
    start = 1'b0;
    e = q.pop_front();
    chk++;
    if ({done, result} !== {1'b1, e.res}) begin errs++; $display("FAIL busy_ignore got done=%b res=%h want done=1 res=%h", done, result, e.res); end
    @(negedge clk);
    chk++;
    if ({busy, done} !== 2'b00) begin errs++; $display("FAIL busy_after got busy=%b done=%b want 00", busy, done); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++)
      run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_mid;
    run(3'd0, 16'h5555, 16'h1111, 4'd0);
    q.push_back(model(3'd0, 16'h12FF, 16'h3401, 4'd0));
    start = 1'b1; cmd = 3'd0; op_a = 16'h12FF; op_b = 16'h3401;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({busy, done, err, flag_c, flag_z, result} !== 21'h0) begin errs++; $display("FAIL async_reset got busy=%b done=%b err=%b c=%b z=%b res=%h want all 0", busy, done, err, flag_c, flag_z, result); end
    chk++;
    if ({alu_oper, alu_a, alu_b, alu_c_in} !== 21'h0) begin errs++; $display("FAIL async_reset_alu got %h want 0", {alu_oper, alu_a, alu_b, alu_c_in}); end
    @(negedge clk);
    chk++;
    if ({done, busy} !== 2'b00) begin errs++; $display("FAIL reset_no_done got done=%b busy=%b want 00", done, busy); end
    q.delete();
    exp_res = '0; exp_c = 1'b0; exp_z = 1'b0;
    rst_n = 1'b1;
    run(3'd0, 16'h12FF, 16'h3401, 4'd0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_shift();
    test_invalid();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ALU data width in bits.
REQ-002 SHALL have parameters OP_ADD=4'h0, OP_ADC=4'h1, OP_SUB=4'h2, OP_SBC=4'h3, OP_LSL=4'h8, OP_LSR=4'h9: the ALU operation codes driven on alu_oper.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, command request; sampled only in IDLE.
REQ-006 SHALL have port cmd, input, 3: 000 ADD2W, 001 SUB2W, 010 CMP2W, 011 LSL, 100 LSR; 101-111 invalid.
REQ-007 SHALL have ports op_a and op_b, input, 2*WIDTH each: operands.
REQ-008 SHALL have port shamt, input, 4: shift count.
REQ-009 SHALL have port busy, output, 1: command in progress.
REQ-010 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: single-cycle pulse for an invalid cmd.
REQ-012 SHALL have port result, output, 2*WIDTH: registered result.
REQ-013 SHALL have ports flag_c and flag_z, output, 1 each: registered carry and zero flags.
REQ-014 SHALL have port alu_oper, output, 4: ALU operation select.
REQ-015 SHALL have ports alu_a and alu_b, output, WIDTH each: ALU operands.
REQ-016 SHALL have port alu_c_in, output, 1: carry into the ALU.
REQ-017 SHALL have ports alu_out (WIDTH), alu_c_out (1) and alu_z_out (1), input: combinational ALU response in the same cycle.

Function
REQ-018 SHALL implement the FSM states IDLE, LO, HI and SHIFT.
REQ-019 In IDLE, start=1 with a valid cmd SHALL latch cmd, op_a, op_b and shamt at the edge; ADD2W, SUB2W and CMP2W go to LO, and LSL and LSR go to SHIFT.
REQ-020 start while busy=1 SHALL be ignored; the latched operands SHALL NOT change during a command.
REQ-021 busy SHALL be 1 exactly in LO, HI and SHIFT.
REQ-022 In LO, the ALU SHALL receive the low WIDTH bits of the operands with alu_oper = OP_ADD (ADD2W) or OP_SUB (SUB2W, CMP2W), alu_c_in=0; at the edge, the block SHALL capture alu_out into a low-result register, capture alu_c_out into an internal carry, capture alu_z_out into an internal z_lo, and go to HI.
REQ-023 In HI, the ALU SHALL receive the high WIDTH bits with alu_oper = OP_ADC or OP_SBC and alu_c_in = the internal carry.
REQ-024 At the edge ending HI, flag_c SHALL become alu_c_out and flag_z SHALL become z_lo AND alu_z_out.
REQ-025 At the edge ending HI, result SHALL become {alu_out, low-result} for ADD2W and SUB2W, and SHALL be unchanged for CMP2W.
REQ-026 At the edge ending HI, done SHALL be set to 1 and the FSM SHALL return to IDLE.
REQ-027 The carry convention SHALL be no-borrow: for subtraction, c=1 means a>=b.
REQ-028 SHIFT SHALL drive alu_oper = OP_LSL or OP_LSR and alu_b=0; alu_a SHALL be the low WIDTH bits of op_a in the first shift cycle, and the previous cycle's alu_out in later cycles.
REQ-029 SHIFT SHALL run max(shamt,1) cycles, using a down-counter.
REQ-030 At the edge ending the final SHIFT cycle, result SHALL become {0, alu_out}, flag_c SHALL become alu_c_out (the last bit shifted out) and flag_z SHALL become alu_z_out; done SHALL be set to 1 and the FSM SHALL return to IDLE.
REQ-031 shamt=0 SHALL be treated as a 1-cycle no-shift command: result = {0, low op_a}, flag_c unchanged, flag_z = (low op_a == 0).
REQ-032 shamt >= WIDTH SHALL produce result 0 and flag_z=1.
REQ-033 Latency SHALL be: 2-word commands assert done 2 edges after the start edge; shifts assert done max(shamt,1) edges after the start edge.
REQ-034 An invalid cmd SHALL stay in IDLE and pulse both err and done for 1 cycle, leaving result and flags unchanged.
REQ-035 done and err SHALL each be high for exactly one cycle per command; a start sampled in the same cycle as done=1 SHALL be accepted.
REQ-036 In IDLE, the block SHALL drive alu_oper=OP_ADD, alu_a=0, alu_b=0 and alu_c_in=0.
REQ-037 result and flags SHALL hold their values until a later command updates them.

Reset
REQ-038 rst_n=0 SHALL immediately force the FSM to IDLE and set busy=0, done=0, err=0, result=0, flag_c=0, flag_z=0, all internal registers=0 and the IDLE ALU drive values; this SHALL apply mid-command as well, with the command discarded.
REQ-039 After rst_n rises, the first start SHALL be honoured on the first clock edge.

Verification
REQ-040 ADD2W, WIDTH=8, 0xFFFF+0x0001 -> result=0x0000, flag_c=1, flag_z=1, done 2 edges after start.
REQ-041 SUB2W 0x0100-0x0001 -> LO cycle alu_out=0xFF with c=0, HI cycle alu_c_in=0 -> result=0x00FF, flag_c=1, flag_z=0.
REQ-042 CMP2W 0x1234 vs 0x1234 with prior result 0xABCD -> result stays 0xABCD, flag_c=1, flag_z=1.
REQ-043 LSR on 0x0081 with shamt=3 -> busy for 3 cycles, result=0x0010, flag_c=0, flag_z=0; LSL on 0x0081 with shamt=1 -> result=0x0002, flag_c=1.
REQ-044 cmd=111 -> err=1 and done=1 for 1 cycle, busy stays 0, result and flags unchanged; start during busy -> ignored.
REQ-045 rst_n pulsed low during the HI cycle of an ADD2W -> all outputs 0 asynchronously, no done pulse; a new ADD2W started after reset completes correctly.
